accumulator_unit: RTL and testbench
===================================

ACCUMULATOR_UNIT -- requirements
Module: accumulator_unit

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  unit can accept a command.
REQ-006 cmd_op  input  2  command code: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-007 cmd_data  input  4  operand b for ADD/SUB; value for LOAD; ignored for CLEAR.
REQ-008 res_valid  output  1  result fields valid.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 acc  output  4  accumulator value.
REQ-011 cout  output  1  carry-out of last ADD/SUB; 0 after LOAD/CLEAR.
REQ-012 ovf  output  1  signed overflow of last ADD/SUB; 0 after LOAD/CLEAR.
REQ-013 ovf_sticky  output  1  OR of every ovf since reset or CLEAR.
REQ-014 op_count  output  4  number of completed commands, wraps 1111->0000.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESULT; reset state IDLE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 on a rising edge.
REQ-017 On accept, op and data SHALL be latched into operand registers and the FSM SHALL move IDLE->EXEC.
REQ-018 In EXEC the adder/subtractor SHALL see a=acc, b=latched data, select=1 for SUB and 0 otherwise.
REQ-019 At the EXEC edge, acc/cout/ovf SHALL be updated: ADD/SUB from adder r/cout/ovf; LOAD acc=data, cout=0, ovf=0; CLEAR acc=0, cout=0, ovf=0.
REQ-020 At the same edge the FSM SHALL move to RESULT, op_count SHALL increment by 1 (mod 16), and ovf_sticky SHALL be set if ovf is set, or cleared if the op is CLEAR.
REQ-021 res_valid SHALL be 1 only in RESULT, so acceptance to res_valid latency is exactly 2 cycles.
REQ-022 In RESULT, all outputs SHALL hold stable until res_ready=1; then the FSM SHALL return to IDLE on that edge.
REQ-023 A command SHALL NOT be accepted in EXEC or RESULT; cmd_valid held high there SHALL have no effect. Throughput is at most one command per 3 cycles.
REQ-024 SUB SHALL compute acc - data in 4-bit two's complement; cout=1 means no borrow.
REQ-025 ovf SHALL be signed overflow: operands of equal effective sign giving a result of the opposite sign.
REQ-026 All arithmetic SHALL be 4-bit with wrap-around and no saturation.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force state=IDLE and acc=0, cout=0, ovf=0, ovf_sticky=0, op_count=0, res_valid=0 and operand registers=0; cmd_ready SHALL be 1 while in IDLE.
REQ-028 Reset asserted in EXEC or RESULT SHALL abandon the in-flight command, with no acc update and no count increment.
REQ-029 On deassertion, the first command SHALL be accepted no earlier than the first rising edge after rst_n=1.

Structure
REQ-030 Command codes (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR) and state encodings SHALL live in a shared package, accumulator_pkg.
REQ-031 The arithmetic SHALL be one instance of the existing adder_subtractor sub-module (ports select, a, b, r, cout, ovf); no separate adder SHALL be written.

Verification
REQ-032 Reset then LOAD 0111, ADD 0001 -> acc=1000, cout=0, ovf=1, ovf_sticky=1, op_count=2.
REQ-033 LOAD 0011, SUB 0101 -> acc=1110, cout=0, ovf=0; then LOAD 0000, SUB 0000 -> acc=0000, cout=1.
REQ-034 LOAD 1111, ADD 0001 -> acc=0000, cout=1, ovf=0; then CLEAR -> ovf_sticky=0, acc=0000.
REQ-035 res_ready held 0 for 5 cycles in RESULT -> outputs stable, cmd_ready=0, and a second cmd_valid pulse is not accepted; with res_ready=1, IDLE follows on the next edge.
REQ-036 rst_n pulsed low during EXEC of ADD 0001 (acc=0101) -> acc=0000, op_count=0, res_valid=0 asynchronously, with no result beat.
REQ-037 Issue 17 back-to-back LOADs -> op_count wraps to 0001, and res_valid is asserted exactly 2 cycles after each accept.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared command codes, FSM state encodings and widths for the accumulator unit.
package accumulator_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_RESULT = 2'b10
  } state_e;

  // ADD and SUB go through the adder; LOAD and CLEAR bypass it.
  function automatic logic uses_adder(op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Ripple-carry adder/subtractor: select=0 gives a+b, select=1 gives a-b (cout=1 means no borrow).
module adder_subtractor #(
  parameter int W = 4
) (
  input  logic         select,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         cout,
  output logic         ovf
);

  logic [W:0]   carry;
  logic [W-1:0] b_eff;

  // Subtraction is a + ~b + 1, the +1 entering as carry-in.
  assign carry[0] = select;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign b_eff[gi]     = b[gi] ^ select;
    assign r[gi]         = a[gi] ^ b_eff[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
  end

  assign cout = carry[W];
  // Carry into and out of the sign bit differ exactly when equal-sign operands flip sign.
  assign ovf  = carry[W] ^ carry[W-1];

endmodule

// File: rtl/accumulator_unit.sv
// Three-state command/result accumulator: accept in IDLE, compute in EXEC, hold result in RESULT.
module accumulator_unit
  import accumulator_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] acc,
  output logic              cout,
  output logic              ovf,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_reg, state_next;
  op_e               op_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic              cout_reg, cout_next;
  logic              ovf_reg, ovf_next;
  logic              sticky_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              accept;
  logic              exec_en;

  logic [DATA_W-1:0] sum_r;
  logic              sum_cout;
  logic              sum_ovf;

  adder_subtractor #(.W(DATA_W)) u_addsub (
    .select (op_reg == OP_SUB),
    .a      (acc_reg),
    .b      (data_reg),
    .r      (sum_r),
    .cout   (sum_cout),
    .ovf    (sum_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    exec_en    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_en    = 1'b1;
        state_next = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    acc_next  = '0;
    cout_next = 1'b0;
    ovf_next  = 1'b0;
    if (uses_adder(op_reg)) begin
      acc_next  = sum_r;
      cout_next = sum_cout;
      ovf_next  = sum_ovf;
    end else if (op_reg == OP_LOAD) begin
      acc_next = data_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= OP_LOAD;
      data_reg   <= '0;
      acc_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      sticky_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (accept) begin
        op_reg   <= op_e'(cmd_op);
        data_reg <= cmd_data;
      end
      if (exec_en) begin
        acc_reg   <= acc_next;
        cout_reg  <= cout_next;
        ovf_reg   <= ovf_next;
        count_reg <= count_reg + 1'b1;
        // CLEAR wins over a set; LOAD never sets ovf so it leaves the flag alone.
        if (op_reg == OP_CLEAR) begin
          sticky_reg <= 1'b0;
        end else if (ovf_next) begin
          sticky_reg <= 1'b1;
        end
      end
    end
  end

  assign acc        = acc_reg;
  assign cout       = cout_reg;
  assign ovf        = ovf_reg;
  assign ovf_sticky = sticky_reg;
  assign op_count   = count_reg;

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed self-checking bench for accumulator_unit.
module tb_accumulator_unit;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] acc;
  logic       cout;
  logic       ovf;
  logic       ovf_sticky;
  logic [3:0] op_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] C_LOAD  = 2'b00;
  localparam logic [1:0] C_ADD   = 2'b01;
  localparam logic [1:0] C_SUB   = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  accumulator_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .acc        (acc),
    .cout       (cout),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .op_count   (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Offers one command and advances to the RESULT state; lat_ok reports that
  // cmd_ready was seen, res_valid was low one cycle after accept and high two cycles after.
  task automatic issue_cmd(input logic [1:0] op, input logic [3:0] data, output bit lat_ok);
    lat_ok = 1'b1;
    for (int i = 0; i < 8 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) lat_ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b0) lat_ok = 1'b0;
    @(posedge clk); #1;
    if (res_valid !== 1'b1) lat_ok = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({acc, cout, ovf, ovf_sticky, op_count, res_valid} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got={acc=%h cout=%b ovf=%b sticky=%b cnt=%h rv=%b} exp=all zero",
               acc, cout, ovf, ovf_sticky, op_count, res_valid);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: acc=%h cnt=%h ready=%b", acc, op_count, cmd_ready);
  endtask

  task automatic test_overflow();
    bit ok;
    issue_cmd(C_LOAD, 4'b0111, ok);
    checks++;
    if (!ok || acc !== 4'b0111 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL load_0111 got=acc %b c%b o%b lat %b exp=acc 0111 c0 o0 lat 1", acc, cout, ovf, ok);
    end
    $display("LOAD 0111 -> acc=%b", acc);
    release_result();
    issue_cmd(C_ADD, 4'b0001, ok);
    checks++;
    if (!ok || {acc, cout, ovf, ovf_sticky, op_count} !== {4'b1000, 1'b0, 1'b1, 1'b1, 4'd2}) begin
      failures++;
      $display("FAIL add_ovf got=acc %b c%b o%b s%b cnt %0d exp=acc 1000 c0 o1 s1 cnt 2",
               acc, cout, ovf, ovf_sticky, op_count);
    end
    $display("ADD 0001 -> acc=%b cout=%b ovf=%b sticky=%b cnt=%0d", acc, cout, ovf, ovf_sticky, op_count);
    release_result();
  endtask

  task automatic test_sub();
    bit ok;
    issue_cmd(C_LOAD, 4'b0011, ok);
    release_result();
    issue_cmd(C_SUB, 4'b0101, ok);
    checks++;
    if (!ok || {acc, cout, ovf, ovf_sticky, op_count} !== {4'b1110, 1'b0, 1'b0, 1'b1, 4'd4}) begin
      failures++;
      $display("FAIL sub_borrow got=acc %b c%b o%b s%b cnt %0d exp=acc 1110 c0 o0 s1 cnt 4",
               acc, cout, ovf, ovf_sticky, op_count);
    end
    $display("SUB 0011-0101 -> acc=%b cout=%b ovf=%b", acc, cout, ovf);
    release_result();
    issue_cmd(C_LOAD, 4'b0000, ok);
    release_result();
    issue_cmd(C_SUB, 4'b0000, ok);
    checks++;
    if (!ok || {acc, cout, ovf, op_count} !== {4'b0000, 1'b1, 1'b0, 4'd6}) begin
      failures++;
      $display("FAIL sub_zero got=acc %b c%b o%b cnt %0d exp=acc 0000 c1 o0 cnt 6", acc, cout, ovf, op_count);
    end
    $display("SUB 0000-0000 -> acc=%b cout=%b ovf=%b", acc, cout, ovf);
    release_result();
  endtask

  task automatic test_carry_clear();
    bit ok;
    issue_cmd(C_LOAD, 4'b1111, ok);
    release_result();
    issue_cmd(C_ADD, 4'b0001, ok);
    checks++;
    if (!ok || {acc, cout, ovf, op_count} !== {4'b0000, 1'b1, 1'b0, 4'd8}) begin
      failures++;
      $display("FAIL add_carry got=acc %b c%b o%b cnt %0d exp=acc 0000 c1 o0 cnt 8", acc, cout, ovf, op_count);
    end
    $display("ADD 1111+0001 -> acc=%b cout=%b ovf=%b", acc, cout, ovf);
    release_result();
    issue_cmd(C_CLEAR, 4'b1010, ok);
    checks++;
    if (!ok || {acc, cout, ovf, ovf_sticky, op_count} !== {4'b0000, 1'b0, 1'b0, 1'b0, 4'd9}) begin
      failures++;
      $display("FAIL clear got=acc %b c%b o%b s%b cnt %0d exp=acc 0000 c0 o0 s0 cnt 9",
               acc, cout, ovf, ovf_sticky, op_count);
    end
    $display("CLEAR -> acc=%b sticky=%b cnt=%0d", acc, ovf_sticky, op_count);
    release_result();
  endtask

  task automatic test_stall();
    bit ok;
    int bad = 0;
    issue_cmd(C_LOAD, 4'b1010, ok);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2);
      cmd_op    = C_ADD;
      cmd_data  = 4'b0001;
      @(posedge clk); #1;
      if ({acc, cout, ovf, res_valid, cmd_ready, op_count} !== {4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10})
        bad++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL stall_hold got=acc %b rv %b rdy %b cnt %0d bad_cycles %0d exp=acc 1010 rv 1 rdy 0 cnt 10 bad_cycles 0",
               acc, res_valid, cmd_ready, op_count, bad);
    end
    release_result();
    checks++;
    if ({cmd_ready, res_valid, acc, op_count} !== {1'b1, 1'b0, 4'b1010, 4'd10}) begin
      failures++;
      $display("FAIL stall_release got=rdy %b rv %b acc %b cnt %0d exp=rdy 1 rv 0 acc 1010 cnt 10",
               cmd_ready, res_valid, acc, op_count);
    end
    $display("stall: held 5 cycles, released acc=%b cnt=%0d", acc, op_count);
  endtask

  task automatic test_reset_midexec();
    bit ok;
    int beats = 0;
    issue_cmd(C_LOAD, 4'b0101, ok);
    release_result();
    cmd_valid = 1'b1;
    cmd_op    = C_ADD;
    cmd_data  = 4'b0001;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({acc, op_count, res_valid, cmd_ready} !== {4'b0000, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got=acc %b cnt %0d rv %b rdy %b exp=acc 0000 cnt 0 rv 0 rdy 1",
               acc, op_count, res_valid, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (res_valid) beats++;
    end
    checks++;
    if (beats != 0 || acc !== 4'b0000 || op_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_no_beat got=beats %0d acc %b cnt %0d exp=beats 0 acc 0000 cnt 0", beats, acc, op_count);
    end
    $display("reset in EXEC: acc=%b cnt=%0d beats=%0d", acc, op_count, beats);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] d;
    logic [3:0] exp_cnt;
    for (int i = 0; i < 17; i++) begin
      d       = 4'(i * 7 + 3);
      exp_cnt = 4'(i + 1);
      issue_cmd(C_LOAD, d, ok);
      checks++;
      if (!ok || acc !== d || op_count !== exp_cnt) begin
        failures++;
        $display("FAIL b2b_load%0d got=acc %b cnt %0d lat %b exp=acc %b cnt %0d lat 1",
                 i, acc, op_count, ok, d, exp_cnt);
      end
      $display("b2b LOAD #%0d data=%b -> acc=%b cnt=%0d", i, d, acc, op_count);
      release_result();
    end
    checks++;
    if (op_count !== 4'd1) begin
      failures++;
      $display("FAIL b2b_wrap got=%0d exp=1", op_count);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0000;
    res_ready = 1'b0;
    test_reset();
    test_overflow();
    test_sub();
    test_carry_clear();
    test_stall();
    test_reset_midexec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
